// File: rtl/instruction_fetch_pkg.sv
// Shared types and constants for the instruction fetch slice.
// Compile-time option: INSTRUCTION_FETCH_TRACE_EN (see instruction_fetch.sv).
package mips_fetch_pkg;

   typedef enum logic [0:0] {
      RUN  = 1'b0,
      HALT = 1'b1
   } fetch_state_t;

   localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_HALT_WORD  = 32'hFFFF_FFFF;
   localparam logic [31:0] DEFAULT_ADDR_LIMIT = 32'h0000_03FC;
   localparam logic [31:0] INSTR_BYTES        = 32'd4;

   // Word-align a byte address by dropping its two low bits.
   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Bus between the fetch unit, the instruction memory and the pipeline.
// master = fetch unit, slave = memory plus surrounding pipeline stages.
interface instruction_fetch_if;

   logic        stall;
   logic        branch_valid;
   logic [31:0] branch_target;
   logic [31:0] imem_address;
   logic [31:0] imem_instruction;
   logic        fetch_valid;
   logic [31:0] fetch_instruction;
   logic [31:0] fetch_pc_plus4;
   logic        halted;

   modport master (
      input  stall, branch_valid, branch_target, imem_instruction,
      output imem_address, fetch_valid, fetch_instruction, fetch_pc_plus4, halted
   );

   modport slave (
      output stall, branch_valid, branch_target, imem_instruction,
      input  imem_address, fetch_valid, fetch_instruction, fetch_pc_plus4, halted
   );

endinterface

// File: rtl/instruction_fetch_pc_reg.sv
// Program counter register: reset load, hold, redirect and sequential increment.
// Redirect takes priority over increment; with neither asserted the PC holds.
module fetch_pc_reg
   import mips_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        advance,
   output logic [31:0] pc
);

   // PC update: redirect wins, then increment, otherwise hold.
   // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc <= RESET_PC;
      end else if (redirect) begin
         pc <= align_word(redirect_pc);
      end else if (advance) begin
         pc <= pc + INSTR_BYTES;
      end
   end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, drives the combinational instruction memory and
// captures the returned word into the IF/ID register. Stops permanently on the
// halt word or when the PC runs past the last valid word.
// Optional build macro INSTRUCTION_FETCH_TRACE_EN adds a fetch counter and
// simulation trace messages; ports and cycle behaviour are unchanged.
module instruction_fetch
   import mips_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
   parameter logic [31:0] HALT_WORD  = DEFAULT_HALT_WORD,
   parameter logic [31:0] ADDR_LIMIT = DEFAULT_ADDR_LIMIT
) (
   input  logic                 clk,
   input  logic                 rst_n,
   instruction_fetch_if.master  bus
);

   localparam logic [0:0] S_RUN  = RUN;
   localparam logic [0:0] S_HALT = HALT;

   logic [0:0]  state;
   logic [31:0] pc;
   logic        in_run;
   logic        take_branch;
   logic        halt_hit;
   logic        enter_halt;
   logic        accept;
   logic        if_valid;
   logic [31:0] if_instruction;
   logic [31:0] if_pc_plus4;

   // Per-cycle decision in RUN: branch > stall > halt detection > accept.
   assign in_run      = (state == S_RUN);
   assign take_branch = in_run && bus.branch_valid;
   assign halt_hit    = (bus.imem_instruction == HALT_WORD) || (pc > ADDR_LIMIT);
   assign enter_halt  = in_run && !bus.branch_valid && !bus.stall && halt_hit;
   assign accept      = in_run && !bus.branch_valid && !bus.stall && !halt_hit;

   fetch_pc_reg #(
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .clk         (clk),
      .rst_n       (rst_n),
      .redirect    (take_branch),
      .redirect_pc (bus.branch_target),
      .advance     (accept),
      .pc          (pc)
   );

   // State machine: RUN until halt is detected; only reset leaves HALT.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_RUN;
      end else if (enter_halt) begin
         state <= S_HALT;
      end
   end

   // IF/ID register: squash on branch or halt, capture on accept, else hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         if_valid       <= 1'b0;
         if_instruction <= 32'h0;
         if_pc_plus4    <= 32'h0;
      end else if (take_branch || enter_halt) begin
         if_valid <= 1'b0;
      end else if (accept) begin
         if_valid       <= 1'b1;
         if_instruction <= bus.imem_instruction;
         if_pc_plus4    <= pc + INSTR_BYTES;
      end
   end

`ifdef INSTRUCTION_FETCH_TRACE_EN
   logic [31:0] fetch_count;

   // Trace: count accepted fetches and report them, plus the total on halt.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_count <= 32'h0;
      end else begin
         if (accept) begin
            fetch_count <= fetch_count + 32'd1;
            $display("instruction_fetch: pc=%h instr=%h", pc, bus.imem_instruction);
         end
         if (enter_halt) begin
            $display("instruction_fetch: halted after %0d fetches", fetch_count);
         end
      end
   end
`endif

   assign bus.imem_address      = pc;
   assign bus.fetch_valid       = if_valid;
   assign bus.fetch_instruction = if_instruction;
   assign bus.fetch_pc_plus4    = if_pc_plus4;
   assign bus.halted            = (state == S_HALT);

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus a
// randomized run against a rule-level reference model of the fetch stage.
module tb_instruction_fetch;
   import mips_fetch_pkg::*;

   localparam logic [31:0] HW    = 32'hFFFF_FFFF;
   localparam logic [31:0] LIMIT = 32'h0000_03FC;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   instruction_fetch_if bus();

   instruction_fetch dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Combinational word-indexed instruction memory.
   logic [31:0] mem [0:255];
   assign bus.imem_instruction = mem[bus.imem_address[9:2]];

   int checks   = 0;
   int failures = 0;

   // Reference model state.
   logic [31:0] m_pc;
   logic        m_valid;
   logic [31:0] m_instr;
   logic [31:0] m_pcp4;
   logic        m_halted;

   // Apply the fetch rules for one clock using the inputs currently driven.
   task automatic model_step();
      logic [31:0] word;
      word = mem[m_pc[9:2]];
      if (!m_halted) begin
         if (bus.branch_valid) begin
            m_pc    = bus.branch_target & ~32'd3;
            m_valid = 1'b0;
         end else if (bus.stall) begin
            // everything holds
         end else if (word == HW || m_pc > LIMIT) begin
            m_halted = 1'b1;
            m_valid  = 1'b0;
         end else begin
            m_instr = word;
            m_pcp4  = m_pc + 32'd4;
            m_valid = 1'b1;
            m_pc    = m_pc + 32'd4;
         end
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   // Assert reset between edges and clear the model; releases reset in the same cycle.
   task automatic reset_and_release();
      @(posedge clk);
      #1;
      bus.stall         = 1'b0;
      bus.branch_valid  = 1'b0;
      bus.branch_target = 32'h0;
      rst_n    = 1'b0;
      m_pc     = 32'h0;
      m_valid  = 1'b0;
      m_instr  = 32'h0;
      m_pcp4   = 32'h0;
      m_halted = 1'b0;
      #2;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      bus.stall = 1'b0; bus.branch_valid = 1'b0; bus.branch_target = 32'h0;
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      rst_n = 1'b0;
      #1;
      checks++; if (bus.imem_address !== 32'h0) begin failures++; $display("FAIL reset_pc actual=%h expected=%h", bus.imem_address, 32'h0); end
      checks++; if (bus.fetch_valid !== 1'b0) begin failures++; $display("FAIL reset_valid actual=%b expected=0", bus.fetch_valid); end
      checks++; if (bus.fetch_instruction !== 32'h0) begin failures++; $display("FAIL reset_instr actual=%h expected=0", bus.fetch_instruction); end
      checks++; if (bus.fetch_pc_plus4 !== 32'h0) begin failures++; $display("FAIL reset_pcp4 actual=%h expected=0", bus.fetch_pc_plus4); end
      checks++; if (bus.halted !== 1'b0) begin failures++; $display("FAIL reset_halted actual=%b expected=0", bus.halted); end
   endtask

   task automatic test_sequential();
      for (int i = 0; i < 256; i++) mem[i] = HW;
      mem[0] = 32'h2008_0001;
      mem[1] = 32'h2009_0002;
      mem[2] = 32'h0109_5020;
      mem[3] = HW;
      reset_and_release();
      checks++; if (bus.fetch_valid !== 1'b0) begin failures++; $display("FAIL seq_valid_at_release actual=%b expected=0", bus.fetch_valid); end
      checks++; if (bus.imem_address !== 32'h0) begin failures++; $display("FAIL seq_addr0 actual=%h expected=0", bus.imem_address); end
      tick();
      checks++; if (bus.imem_address !== 32'h4) begin failures++; $display("FAIL seq_addr4 actual=%h expected=4", bus.imem_address); end
      checks++; if (bus.fetch_valid !== 1'b1) begin failures++; $display("FAIL seq_valid_rise actual=%b expected=1", bus.fetch_valid); end
      checks++; if (bus.fetch_pc_plus4 !== 32'h4) begin failures++; $display("FAIL seq_pcp4_4 actual=%h expected=4", bus.fetch_pc_plus4); end
      checks++; if (bus.fetch_instruction !== 32'h2008_0001) begin failures++; $display("FAIL seq_instr0 actual=%h expected=20080001", bus.fetch_instruction); end
      tick();
      checks++; if (bus.imem_address !== 32'h8) begin failures++; $display("FAIL seq_addr8 actual=%h expected=8", bus.imem_address); end
      checks++; if (bus.fetch_pc_plus4 !== 32'h8) begin failures++; $display("FAIL seq_pcp4_8 actual=%h expected=8", bus.fetch_pc_plus4); end
      // Stall three cycles at pc=8.
      bus.stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (bus.imem_address !== 32'h8) begin failures++; $display("FAIL stall_addr[%0d] actual=%h expected=8", i, bus.imem_address); end
         checks++; if (bus.fetch_instruction !== 32'h2009_0002) begin failures++; $display("FAIL stall_instr[%0d] actual=%h expected=20090002", i, bus.fetch_instruction); end
         checks++; if (bus.fetch_valid !== 1'b1) begin failures++; $display("FAIL stall_valid[%0d] actual=%b expected=1", i, bus.fetch_valid); end
      end
      bus.stall = 1'b0;
      tick();
      checks++; if (bus.imem_address !== 32'hC) begin failures++; $display("FAIL unstall_addr actual=%h expected=c", bus.imem_address); end
      checks++; if (bus.fetch_pc_plus4 !== 32'hC) begin failures++; $display("FAIL seq_pcp4_12 actual=%h expected=c", bus.fetch_pc_plus4); end
      // Halt word under stall: stall wins.
      bus.stall = 1'b1;
      tick();
      checks++; if (bus.halted !== 1'b0) begin failures++; $display("FAIL stall_over_halt actual=%b expected=0", bus.halted); end
      bus.stall = 1'b0;
      tick();
      checks++; if (bus.halted !== 1'b1) begin failures++; $display("FAIL halt_word_halted actual=%b expected=1", bus.halted); end
      checks++; if (bus.fetch_valid !== 1'b0) begin failures++; $display("FAIL halt_word_valid actual=%b expected=0", bus.fetch_valid); end
      checks++; if (bus.imem_address !== 32'hC) begin failures++; $display("FAIL halt_word_pc actual=%h expected=c", bus.imem_address); end
      checks++; if (bus.fetch_instruction !== 32'h0109_5020) begin failures++; $display("FAIL halt_word_leak actual=%h expected=01095020", bus.fetch_instruction); end
      // Branch after halt is ignored.
      bus.branch_valid = 1'b1; bus.branch_target = 32'h40;
      tick();
      bus.branch_valid = 1'b0;
      checks++; if (bus.imem_address !== 32'hC) begin failures++; $display("FAIL halt_branch_pc actual=%h expected=c", bus.imem_address); end
      checks++; if (bus.halted !== 1'b1) begin failures++; $display("FAIL halt_branch_halted actual=%b expected=1", bus.halted); end
   endtask

   task automatic test_branch();
      logic [31:0] w8;
      for (int i = 0; i < 256; i++) begin
         mem[i] = $urandom;
         if (mem[i] == HW) mem[i] = 32'h0;
      end
      w8 = mem[8];
      reset_and_release();
      tick();
      checks++; if (bus.imem_address !== 32'h4) begin failures++; $display("FAIL br_pre_pc actual=%h expected=4", bus.imem_address); end
      bus.branch_valid = 1'b1; bus.branch_target = 32'h22; bus.stall = 1'b1;
      tick();
      bus.branch_valid = 1'b0; bus.stall = 1'b0;
      checks++; if (bus.imem_address !== 32'h20) begin failures++; $display("FAIL br_target actual=%h expected=20", bus.imem_address); end
      checks++; if (bus.fetch_valid !== 1'b0) begin failures++; $display("FAIL br_bubble actual=%b expected=0", bus.fetch_valid); end
      tick();
      checks++; if (bus.fetch_valid !== 1'b1) begin failures++; $display("FAIL br_resume_valid actual=%b expected=1", bus.fetch_valid); end
      checks++; if (bus.fetch_instruction !== w8) begin failures++; $display("FAIL br_word8 actual=%h expected=%h", bus.fetch_instruction, w8); end
      checks++; if (bus.fetch_pc_plus4 !== 32'h24) begin failures++; $display("FAIL br_pcp4 actual=%h expected=24", bus.fetch_pc_plus4); end
   endtask

   task automatic test_end_of_memory();
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      reset_and_release();
      repeat (256) tick();
      checks++; if (bus.imem_address !== 32'h400) begin failures++; $display("FAIL eom_pc actual=%h expected=400", bus.imem_address); end
      checks++; if (bus.fetch_pc_plus4 !== 32'h400) begin failures++; $display("FAIL eom_last_pcp4 actual=%h expected=400", bus.fetch_pc_plus4); end
      checks++; if (bus.halted !== 1'b0) begin failures++; $display("FAIL eom_early_halt actual=%b expected=0", bus.halted); end
      tick();
      checks++; if (bus.halted !== 1'b1) begin failures++; $display("FAIL eom_halted actual=%b expected=1", bus.halted); end
      checks++; if (bus.fetch_valid !== 1'b0) begin failures++; $display("FAIL eom_valid actual=%b expected=0", bus.fetch_valid); end
      checks++; if (bus.imem_address !== 32'h400) begin failures++; $display("FAIL eom_pc_frozen actual=%h expected=400", bus.imem_address); end
   endtask

   task automatic test_async_reset();
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      checks++; if (bus.imem_address !== 32'h0) begin failures++; $display("FAIL async_pc actual=%h expected=0", bus.imem_address); end
      checks++; if (bus.halted !== 1'b0) begin failures++; $display("FAIL async_halted actual=%b expected=0", bus.halted); end
      checks++; if (bus.fetch_valid !== 1'b0) begin failures++; $display("FAIL async_valid actual=%b expected=0", bus.fetch_valid); end
      checks++; if (bus.fetch_pc_plus4 !== 32'h0) begin failures++; $display("FAIL async_pcp4 actual=%h expected=0", bus.fetch_pc_plus4); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 256; i++) mem[i] = ($urandom_range(0, 31) == 0) ? HW : $urandom;
      reset_and_release();
      for (int n = 0; n < 600; n++) begin
         if (m_halted && $urandom_range(0, 3) == 0) begin
            for (int i = 0; i < 256; i++) mem[i] = ($urandom_range(0, 47) == 0) ? HW : $urandom;
            reset_and_release();
         end
         bus.stall         = ($urandom_range(0, 3) == 0);
         bus.branch_valid  = ($urandom_range(0, 9) == 0);
         bus.branch_target = $urandom_range(0, 32'h47F);
         tick();
         checks++; if (bus.imem_address !== m_pc) begin failures++; $display("FAIL rnd_pc cyc=%0d actual=%h expected=%h", n, bus.imem_address, m_pc); end
         checks++; if (bus.fetch_valid !== m_valid) begin failures++; $display("FAIL rnd_valid cyc=%0d actual=%b expected=%b", n, bus.fetch_valid, m_valid); end
         checks++; if (bus.halted !== m_halted) begin failures++; $display("FAIL rnd_halted cyc=%0d actual=%b expected=%b", n, bus.halted, m_halted); end
         if (m_valid) begin
            checks++; if (bus.fetch_instruction !== m_instr) begin failures++; $display("FAIL rnd_instr cyc=%0d actual=%h expected=%h", n, bus.fetch_instruction, m_instr); end
            checks++; if (bus.fetch_pc_plus4 !== m_pcp4) begin failures++; $display("FAIL rnd_pcp4 cyc=%0d actual=%h expected=%h", n, bus.fetch_pc_plus4, m_pcp4); end
         end
      end
      bus.stall = 1'b0;
      bus.branch_valid = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_sequential();
      test_branch();
      test_end_of_memory();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch-side initiator for the combinational, word-indexed instruction memory. It owns the PC, drives the memory address, and captures the returned word into an IF/ID register for decode.
- Handles sequential fetch, stalls, and branch/jump redirects.
- Detects the all-ones halt word and the end of memory. It freezes fetch in hardware instead of relying on a simulator stop.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- HALT_WORD, 32'hFFFF_FFFF, instruction encoding that terminates fetch; unprogrammed memory reads as this value.
- ADDR_LIMIT, 32'h0000_03FC, byte address of the last valid word (256 words x 4 bytes).

Ports:
- clk  in  1  system clock, all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall  in  1  hold PC and IF/ID contents this cycle.
- branch_valid  in  1  redirect request from a later stage.
- branch_target  in  32  redirect byte address.
- imem_address  out  32  byte address to instruction memory; memory indexes with bits [9:2].
- imem_instruction  in  32  combinational read data for imem_address.
- fetch_valid  out  1  fetch_instruction/fetch_pc_plus4 hold a live instruction.
- fetch_instruction  out  32  IF/ID instruction register.
- fetch_pc_plus4  out  32  IF/ID copy of (fetched PC + 4).
- halted  out  1  fetch has stopped permanently.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: pc=RESET_PC, state=RUN, fetch_valid=0, fetch_instruction=32'h0, fetch_pc_plus4=32'h0, halted=0.
- imem_address = pc, purely combinational. Instruction data is sampled in the same cycle, so fetch latency is 1 clk from PC to IF/ID.
- States: RUN and HALT. HALT is left only by reset.
- RUN priority per cycle, highest first:
  1. branch_valid=1: pc <= {branch_target[31:2],2'b00}, fetch_valid <= 0. The current word is squashed, giving a one-cycle bubble. Branch overrides stall. A halt word under a branch is ignored.
  2. stall=1: pc, fetch_valid, fetch_instruction and fetch_pc_plus4 all hold.
  3. (imem_instruction==HALT_WORD) or (pc > ADDR_LIMIT): state <= HALT, halted <= 1, fetch_valid <= 0, pc holds. The halt word never reaches decode.
  4. Otherwise: fetch_instruction <= imem_instruction, fetch_pc_plus4 <= pc+4, fetch_valid <= 1, pc <= pc+4.
- Arithmetic: pc+4 is 32-bit, modulo 2^32. Wrap is irrelevant in practice because the ADDR_LIMIT check fires first.
- Alignment: pc[1:0] is always 2'b00. Misaligned targets are truncated, not trapped.
- HALT: all inputs are ignored, outputs hold, fetch_valid=0, halted=1.
- Reset mid-operation: asynchronous assertion immediately forces the reset values, including from HALT.
- Simultaneous stall and halt word: stall wins; the halt is detected in the first unstalled cycle.

Optional Feature:
- Macro: INSTRUCTION_FETCH_TRACE_EN.
- When defined:
  - An internal 32-bit counter increments on each accepted fetch (case 4).
  - Each accepted fetch issues a $display of the PC and the instruction.
  - Entry to HALT issues a $display of the final count.
- When undefined: no counter, no display statements. Port list and cycle behaviour are identical.

Decomposition:
- Package mips_fetch_pkg holds:
  - the fetch_state_t enum (RUN, HALT);
  - the constants DEFAULT_RESET_PC, DEFAULT_HALT_WORD, DEFAULT_ADDR_LIMIT;
  - INSTR_BYTES=4.
- One sub-module, fetch_pc_reg: the PC register with reset load, hold, redirect and increment controls.
- IF/ID capture, halt detection and the state machine stay in instruction_fetch.

Test Plan:
- Sequential fetch: memory 0..2 = 32'h20080001, 32'h20090002, 32'h01095020; release reset. Expect imem_address 0,4,8 on consecutive cycles; fetch_valid rises 1 clk after reset release; fetch_pc_plus4 = 4,8,12.
- Stall: assert stall for 3 cycles at pc=8. Expect imem_address to stay 8 and fetch_instruction to stay 32'h20090002; pc=12 on the first cycle after stall drops.
- Branch: branch_valid=1, branch_target=32'h0000_0022 with stall=1 at pc=4. Expect pc=32'h20 next cycle, fetch_valid=0 for exactly 1 cycle, then the word at index 8 is captured.
- Halt word: word 3 = 32'hFFFFFFFF. Expect halted=1 after fetching pc=12, fetch_valid=0, pc frozen at 12, and the halt word never in fetch_instruction. Asserting branch_valid afterwards has no effect.
- End of memory: fill all 256 words with 32'h00000000. Expect halted=1 when pc reaches 32'h400, last fetch_pc_plus4 = 32'h400.
- Async reset in HALT: drop rst_n mid-cycle. Expect pc=RESET_PC, halted=0 and fetch_valid=0 immediately, without a clock edge.
